// File: rtl/ofifo_drain.sv
// Drains num_vec psum vectors from the OFIFO into consecutive psum-SRAM addresses; pop->write latency 1 cycle.
// Backpressure: hold=1 or ofifo_valid=0 stalls popping only, a write already launched by the previous pop still fires.
module ofifo_drain #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int addr_bw = 11,
   parameter int cnt_bw  = 11
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [cnt_bw-1:0]      num_vec,
   input  logic [addr_bw-1:0]     base_addr,
   input  logic                   hold,
   input  logic                   ofifo_valid,
   input  logic [col*psum_bw-1:0] ofifo_data,
   output logic                   ofifo_rd,
   output logic                   psum_wen,
   output logic [addr_bw-1:0]     psum_addr,
   output logic [col*psum_bw-1:0] psum_wdata,
   output logic                   busy,
   output logic                   done,
   output logic [cnt_bw-1:0]      vec_cnt
);

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

   state_t               state;
   logic [cnt_bw-1:0]    remaining;
   logic [addr_bw-1:0]   wr_ptr;
   logic                 pop;

   // Pop decision is combinational so a vector can leave the FIFO every cycle.
   assign pop      = (state == DRAIN) && ofifo_valid && !hold && (remaining != '0);
   assign ofifo_rd = pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         remaining  <= '0;
         wr_ptr     <= '0;
         psum_wen   <= 1'b0;
         psum_addr  <= '0;
         psum_wdata <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         vec_cnt    <= '0;
      end else begin
         psum_wen <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  remaining <= num_vec;
                  wr_ptr    <= base_addr;
                  vec_cnt   <= '0;
                  busy      <= 1'b1;
                  state     <= (num_vec == '0) ? DONE : DRAIN;
               end
            end
            DRAIN: begin
               if (pop) begin
                  psum_wdata <= ofifo_data;
                  psum_addr  <= wr_ptr;
                  psum_wen   <= 1'b1;
                  wr_ptr     <= wr_ptr + addr_bw'(1);
                  remaining  <= remaining - cnt_bw'(1);
                  vec_cnt    <= vec_cnt + cnt_bw'(1);
                  if (remaining == cnt_bw'(1))
                     state <= FLUSH;
               end
            end
            FLUSH: begin
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ofifo_drain.sv
// Randomized bench for ofifo_drain: a job-level reference model predicts every output each cycle.
module tb_ofifo_drain;
   localparam int COL = 8;
   localparam int PBW = 16;
   localparam int AW  = 11;
   localparam int CW  = 11;
   localparam int W   = COL * PBW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [CW-1:0] num_vec;
   logic [AW-1:0] base_addr;
   logic          hold;
   logic          ofifo_valid;
   logic [W-1:0]  ofifo_data;
   logic          ofifo_rd;
   logic          psum_wen;
   logic [AW-1:0] psum_addr;
   logic [W-1:0]  psum_wdata;
   logic          busy;
   logic          done;
   logic [CW-1:0] vec_cnt;

   ofifo_drain #(.col(COL), .psum_bw(PBW), .addr_bw(AW), .cnt_bw(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .num_vec(num_vec), .base_addr(base_addr),
      .hold(hold), .ofifo_valid(ofifo_valid), .ofifo_data(ofifo_data), .ofifo_rd(ofifo_rd),
      .psum_wen(psum_wen), .psum_addr(psum_addr), .psum_wdata(psum_wdata), .busy(busy),
      .done(done), .vec_cnt(vec_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Contents of the OFIFO as seen by the drain; head is element 0.
   logic [W-1:0] fifo_q[$];

   // Reference model: job bookkeeping plus the outputs the DUT must show this cycle.
   bit            m_active;
   int            m_left;
   logic [AW-1:0] m_ptr;
   logic [CW-1:0] m_cnt;
   longint        m_done_edge;
   logic          e_wen, e_done;
   logic [AW-1:0] e_addr;
   logic [W-1:0]  e_data;
   longint        ecnt = 0;

   // Observations of the DUT for the directed literal checks.
   int            n_rd, n_wr, rd_in_gap;
   logic [AW-1:0] wr_addr[$];
   longint        last_pop_edge, done_edge, start_edge;
   bit            in_gap;

   function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [W-1:0] rand_vec();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always @(posedge clk or negedge reset) begin : mdl
      bit was_active;
      if (!reset) begin
         m_active    = 1'b0;
         m_left      = 0;
         m_ptr       = '0;
         m_cnt       = '0;
         m_done_edge = -1;
         e_wen       = 1'b0;
         e_done      = 1'b0;
         e_addr      = '0;
         e_data      = '0;
      end else begin
         ecnt++;
         was_active = m_active;
         e_wen      = 1'b0;
         e_done     = 1'b0;
         if (was_active && m_left > 0 && ofifo_valid && !hold) begin
            e_wen  = 1'b1;
            e_addr = m_ptr;
            e_data = fifo_q.pop_front();
            m_ptr  = m_ptr + 1'b1;
            m_cnt  = m_cnt + 1'b1;
            m_left--;
            if (m_left == 0) m_done_edge = ecnt + 2;
         end else if (was_active && ecnt == m_done_edge) begin
            e_done   = 1'b1;
            m_active = 1'b0;
         end
         if (!was_active && start) begin
            m_active    = 1'b1;
            m_left      = int'(num_vec);
            m_ptr       = base_addr;
            m_cnt       = '0;
            m_done_edge = (num_vec == '0) ? ecnt + 1 : -1;
         end
      end
   end

   always @(negedge clk) begin : mon
      logic exp_rd;
      exp_rd = m_active && m_left > 0 && ofifo_valid && !hold;
      chk("ofifo_rd", W'(ofifo_rd), W'(exp_rd));
      chk("psum_wen", W'(psum_wen), W'(e_wen));
      chk("psum_addr", W'(psum_addr), W'(e_addr));
      chk("psum_wdata", psum_wdata, e_data);
      chk("busy", W'(busy), W'(m_active));
      chk("done", W'(done), W'(e_done));
      chk("vec_cnt", W'(vec_cnt), W'(m_cnt));
      if (ofifo_rd) begin
         n_rd++;
         last_pop_edge = ecnt + 1;
         if (in_gap) rd_in_gap++;
      end
      if (psum_wen) begin
         n_wr++;
         wr_addr.push_back(psum_addr);
      end
      if (done) done_edge = ecnt;
      if (start) start_edge = ecnt + 1;
   end

   // mode 0: always ready; 1: hold toggles; 2: five-cycle valid gap; 3: random.
   task automatic drive(input int mode, input int k);
      bit gate;
      gate   = 1'b1;
      hold   = 1'b0;
      in_gap = 1'b0;
      case (mode)
         1: hold = (k % 2 == 1);
         2: if (k >= 2 && k <= 6) begin gate = 1'b0; in_gap = 1'b1; end
         3: begin
            hold = ($urandom_range(0, 3) == 0);
            gate = ($urandom_range(0, 2) != 0);
         end
         default: ;
      endcase
      ofifo_valid = gate && (fifo_q.size() > 0);
      ofifo_data  = ofifo_valid ? fifo_q[0] : rand_vec();
   endtask

   task automatic run_job(input int n, input logic [AW-1:0] base, input int mode, input int stop_after);
      for (int i = 0; i < n; i++) fifo_q.push_back(rand_vec());
      n_rd = 0; n_wr = 0; rd_in_gap = 0;
      wr_addr.delete();
      @(posedge clk); #1;
      start = 1'b1; num_vec = CW'(n); base_addr = base;
      drive(mode, 0);
      @(posedge clk); #1;
      start = 1'b0; num_vec = CW'($urandom); base_addr = AW'($urandom);
      for (int k = 1; k <= 301; k++) begin
         if (done) break;
         if (stop_after > 0 && n_rd >= stop_after) return;
         if (k == 301) begin
            n_checks++; n_fail++;
            $display("FAIL job_timeout: done not seen, n=%0d mode=%0d", n, mode);
            break;
         end
         drive(mode, k);
         start = (mode == 3 && $urandom_range(0, 7) == 0);
         @(posedge clk); #1;
      end
      start = 1'b0; hold = 1'b0; ofifo_valid = 1'b0; in_gap = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd"}, W'(ofifo_rd), '0);
      chk({tag, "_wen"}, W'(psum_wen), '0);
      chk({tag, "_addr"}, W'(psum_addr), '0);
      chk({tag, "_wdata"}, psum_wdata, '0);
      chk({tag, "_busy"}, W'(busy), '0);
      chk({tag, "_done"}, W'(done), '0);
      chk({tag, "_vec_cnt"}, W'(vec_cnt), '0);
   endtask

   initial begin
      logic [AW-1:0] exp_a[3];
      reset = 1'b0; start = 1'b0; hold = 1'b0; ofifo_valid = 1'b0;
      num_vec = '0; base_addr = '0; ofifo_data = '0;
      #3;
      chk_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Back-to-back drain of four vectors.
      run_job(4, AW'('h10), 0, 0);
      chk("t1_n_wr", W'(n_wr), W'(4));
      for (int i = 0; i < 4; i++) chk("t1_addr", W'(wr_addr[i]), W'('h10 + i));
      chk("t1_vec_cnt", W'(vec_cnt), W'(4));
      chk("t1_done_lat", W'(done_edge - last_pop_edge), W'(2));

      // hold toggling every cycle.
      run_job(3, AW'('h40), 1, 0);
      chk("t2_n_wr", W'(n_wr), W'(3));
      chk("t2_n_rd", W'(n_rd), W'(3));

      // Five-cycle ofifo_valid gap mid-job.
      run_job(6, AW'('h80), 2, 0);
      chk("t3_rd_in_gap", W'(rd_in_gap), W'(0));
      chk("t3_n_wr", W'(n_wr), W'(6));

      // Empty job.
      run_job(0, AW'('h100), 0, 0);
      chk("t4_n_rd", W'(n_rd), W'(0));
      chk("t4_n_wr", W'(n_wr), W'(0));
      chk("t4_vec_cnt", W'(vec_cnt), W'(0));
      chk("t4_done_lat", W'(done_edge - start_edge), W'(1));

      // Address wrap at the top of the SRAM.
      run_job(3, AW'('h7FE), 0, 0);
      exp_a[0] = AW'('h7FE); exp_a[1] = AW'('h7FF); exp_a[2] = AW'('h000);
      for (int i = 0; i < 3; i++) chk("t5_addr", W'(wr_addr[i]), W'(exp_a[i]));

      // Reset after two of five pops, then a fresh single-vector job.
      run_job(5, AW'('h200), 0, 2);
      reset = 1'b0;
      #1;
      chk_all_zero("t6_reset");
      fifo_q.delete();
      ofifo_valid = 1'b0; start = 1'b0; hold = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      run_job(1, AW'('h300), 0, 0);
      chk("t6_n_rd", W'(n_rd), W'(1));
      chk("t6_n_wr", W'(n_wr), W'(1));

      // Randomized jobs with random hold, valid gaps and stray start pulses.
      for (int j = 0; j < 25; j++) begin
         int n;
         n = $urandom_range(0, 6);
         run_job(n, AW'($urandom), 3, 0);
         chk("rand_n_wr", W'(n_wr), W'(n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
